// File: rtl/shared_main_memory_if.sv
// Cache-miss bus shared by the instruction and data caches and the unified main memory.
// master = cache side, slave = memory side.
interface shared_main_memory_if #(
  parameter int unsigned ADDR_BITS  = 28,
  parameter int unsigned BLOCK_BITS = 128
);
  logic                  INST_READ;
  logic [ADDR_BITS-1:0]  INST_ADDRESS;
  logic [BLOCK_BITS-1:0] INST_READDATA;
  logic                  INST_BUSYWAIT;
  logic                  DATA_READ;
  logic                  DATA_WRITE;
  logic [ADDR_BITS-1:0]  DATA_ADDRESS;
  logic [BLOCK_BITS-1:0] DATA_WRITEDATA;
  logic [BLOCK_BITS-1:0] DATA_READDATA;
  logic                  DATA_BUSYWAIT;

  modport master (
    output INST_READ, INST_ADDRESS, DATA_READ, DATA_WRITE, DATA_ADDRESS, DATA_WRITEDATA,
    input  INST_READDATA, INST_BUSYWAIT, DATA_READDATA, DATA_BUSYWAIT
  );

  modport slave (
    input  INST_READ, INST_ADDRESS, DATA_READ, DATA_WRITE, DATA_ADDRESS, DATA_WRITEDATA,
    output INST_READDATA, INST_BUSYWAIT, DATA_READDATA, DATA_BUSYWAIT
  );
endinterface

// File: rtl/shared_main_memory.sv
// Unified block memory serving the instruction and data cache miss ports,
// with fixed-priority or round-robin arbitration and a fixed access latency.
module shared_main_memory #(
  parameter int unsigned BLOCK_BITS = 128,
  parameter int unsigned ADDR_BITS  = 28,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned ARB_MODE   = 0
) (
  input logic                 CLK,
  input logic                 RESET,
  shared_main_memory_if.slave bus
);
  localparam int unsigned IDX_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = $clog2(LATENCY + 1);
  localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);
  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  logic [BLOCK_BITS-1:0] MEM_ARRAY [DEPTH];

  state_t                state_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic                  grant_q;
  logic                  ptr_q;
  logic                  wr_q;
  logic [IDX_BITS-1:0]   idx_q;
  logic [BLOCK_BITS-1:0] wdata_q;
  logic [BLOCK_BITS-1:0] inst_rdata_q;
  logic [BLOCK_BITS-1:0] data_rdata_q;

  logic inst_req;
  logic data_req;
  logic grant_d;
  logic commit;
  logic unused_addr_bits;

  assign inst_req = bus.INST_READ;
  assign data_req = bus.DATA_READ | bus.DATA_WRITE;
  assign commit   = (state_q == ACCESS) && (cnt_q == '0);

  // Upper address bits alias onto the same block.
  assign unused_addr_bits = ^{bus.INST_ADDRESS, bus.DATA_ADDRESS};

  // ptr_q names the preferred port on conflict (0 = inst, 1 = data).
  always_comb begin
    grant_d = PORT_INST;
    if (inst_req && data_req) begin
      grant_d = (ARB_MODE == 0) ? PORT_DATA : ptr_q;
    end else if (data_req) begin
      grant_d = PORT_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= PORT_INST;
      ptr_q        <= PORT_INST;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inst_req || data_req) begin
            grant_q <= grant_d;
            ptr_q   <= ~grant_d;
            cnt_q   <= CNT_LOAD;
            state_q <= ACCESS;
            if (grant_d == PORT_DATA) begin
              idx_q   <= bus.DATA_ADDRESS[IDX_BITS-1:0];
              wr_q    <= bus.DATA_WRITE;
              wdata_q <= bus.DATA_WRITEDATA;
            end else begin
              idx_q <= bus.INST_ADDRESS[IDX_BITS-1:0];
              wr_q  <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            if (!wr_q) begin
              if (grant_q == PORT_DATA) data_rdata_q <= MEM_ARRAY[idx_q];
              else                      inst_rdata_q <= MEM_ARRAY[idx_q];
            end
          end else begin
            cnt_q <= cnt_q - CNT_BITS'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Storage has no reset; reset forces IDLE so an in-flight write never commits.
  always_ff @(posedge CLK) begin
    if (commit && wr_q) MEM_ARRAY[idx_q] <= wdata_q;
  end

  assign bus.INST_BUSYWAIT = inst_req & ~((state_q == DONE) && (grant_q == PORT_INST));
  assign bus.DATA_BUSYWAIT = data_req & ~((state_q == DONE) && (grant_q == PORT_DATA));
  assign bus.INST_READDATA = inst_rdata_q;
  assign bus.DATA_READDATA = data_rdata_q;
endmodule
